// File: rtl/pc_update_unit.sv
// Program-counter update stage: holds PC and the latched branch-target register, selects the next PC.
// Optional bne support is enabled by defining BRANCH_NE_EN (adds the branch_ne input).
module pc_update_unit #(
    parameter int DATA_BUS_WIDTH    = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int WIDTH_OPCODE      = 6,
    parameter logic [DATA_BUS_WIDTH-1:0] RESET_PC = '0,
    parameter int CNT_WIDTH         = 16,
    localparam int JT_W             = INSTRUCTION_WIDTH - WIDTH_OPCODE + 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pc_write,
    input  logic                      pc_write_cond,
    input  logic [1:0]                pc_source,
    input  logic [DATA_BUS_WIDTH-1:0] alu_result,
    input  logic                      alu_zero,
    input  logic                      target_load,
    input  logic [JT_W-1:0]           jump_offset,
`ifdef BRANCH_NE_EN
    input  logic                      branch_ne,
`endif
    output logic [DATA_BUS_WIDTH-1:0] pc,
    output logic [DATA_BUS_WIDTH-1:0] target,
    output logic                      pc_updated,
    output logic                      misaligned,
    output logic [CNT_WIDTH-1:0]      taken_count
);

    logic [DATA_BUS_WIDTH-1:0] r_pc;
    logic [DATA_BUS_WIDTH-1:0] r_target;
    logic                      r_pc_updated;
    logic                      r_misaligned;
    logic [CNT_WIDTH-1:0]      r_taken_count;

    logic                      w_cond_ok;
    logic                      w_write_req;
    logic [DATA_BUS_WIDTH-1:0] w_candidate;
    logic                      w_attempt;
    logic                      w_aligned;
    logic                      w_accept;
    logic                      w_taken;

`ifdef BRANCH_NE_EN
    assign w_cond_ok = alu_zero ^ branch_ne;
`else
    assign w_cond_ok = alu_zero;
`endif

    assign w_write_req = pc_write | (pc_write_cond & w_cond_ok);

    // Source 01 reads the target register before any same-cycle target_load lands.
    always_comb begin
        w_candidate = r_pc;
        case (pc_source)
            2'b00:   w_candidate = alu_result;
            2'b01:   w_candidate = r_target;
            2'b10:   w_candidate = {r_pc[DATA_BUS_WIDTH-1:JT_W], jump_offset};
            default: w_candidate = r_pc;
        endcase
    end

    assign w_attempt = w_write_req & (pc_source != 2'b11) & ~r_misaligned;
    assign w_aligned = (w_candidate[1:0] == 2'b00);
    assign w_accept  = w_attempt & w_aligned;
    assign w_taken   = w_accept & ((pc_source == 2'b01) | (pc_source == 2'b10));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_target      <= '0;
            r_pc_updated  <= 1'b0;
            r_misaligned  <= 1'b0;
            r_taken_count <= '0;
        end else begin
            r_pc_updated <= w_accept;
            if (target_load) begin
                r_target <= alu_result;
            end
            if (w_accept) begin
                r_pc <= w_candidate;
            end
            if (w_taken) begin
                r_taken_count <= r_taken_count + CNT_WIDTH'(1);
            end
            // Sticky: once set, w_attempt blocks every later write until reset.
            if (w_attempt && !w_aligned) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign target      = r_target;
    assign pc_updated  = r_pc_updated;
    assign misaligned  = r_misaligned;
    assign taken_count = r_taken_count;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: a behavioural model checked every cycle plus literal expectations.
module tb_pc_update_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write, pc_write_cond, alu_zero, target_load, branch_ne;
    logic [1:0]  pc_source;
    logic [31:0] alu_result;
    logic [28:0] jump_offset;
    logic [31:0] pc, target;
    logic        pc_updated, misaligned;
    logic [15:0] taken_count;

`ifdef BRANCH_NE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [31:0] m_pc, m_target;
    logic        m_upd, m_mis;
    int          m_cnt;

    always #5 clk = ~clk;

    pc_update_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .target_load   (target_load),
        .jump_offset   (jump_offset),
`ifdef BRANCH_NE_EN
        .branch_ne     (branch_ne),
`endif
        .pc            (pc),
        .target        (target),
        .pc_updated    (pc_updated),
        .misaligned    (misaligned),
        .taken_count   (taken_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: decide what the PC should become from the rules, using plain arithmetic.
    always @(posedge clk) begin : model
        logic        take_branch;
        logic        wants_write;
        logic [31:0] dest;
        if (reset) begin
            m_pc     <= 32'h0;
            m_target <= 32'h0;
            m_upd    <= 1'b0;
            m_mis    <= 1'b0;
            m_cnt    <= 0;
        end else begin
            take_branch = BNE_EN ? (alu_zero != branch_ne) : alu_zero;
            wants_write = pc_write || (pc_write_cond && take_branch);
            if (pc_source == 2'd0)      dest = alu_result;
            else if (pc_source == 2'd1) dest = m_target;
            else                        dest = (m_pc & 32'hE000_0000) + {3'b000, jump_offset};
            m_upd <= 1'b0;
            if (wants_write && pc_source != 2'd3 && !m_mis) begin
                if (dest % 4 != 0) begin
                    m_mis <= 1'b1;
                end else begin
                    m_pc  <= dest;
                    m_upd <= 1'b1;
                    if (pc_source == 2'd1 || pc_source == 2'd2)
                        m_cnt <= (m_cnt + 1) % 65536;
                end
            end
            if (target_load) m_target <= alu_result;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc", pc, m_pc);
            chk("model_target", target, m_target);
            chk("model_pc_updated", {31'b0, pc_updated}, {31'b0, m_upd});
            chk("model_misaligned", {31'b0, misaligned}, {31'b0, m_mis});
            chk("model_taken_count", {16'b0, taken_count}, m_cnt[31:0]);
        end
    end

    // Drive one cycle of inputs (applied just after a negedge), return #1 after the next negedge.
    task automatic apply(input logic pw, input logic pwc, input logic [1:0] src,
                         input logic [31:0] alu, input logic az, input logic tl,
                         input logic [28:0] jo, input logic bne, input bit verbose);
        pc_write = pw; pc_write_cond = pwc; pc_source = src; alu_result = alu;
        alu_zero = az; target_load = tl; jump_offset = jo; branch_ne = bne;
        @(negedge clk);
        #1;
        if (verbose)
            $display("txn pw=%0b pwc=%0b src=%0d alu=%h az=%0b tl=%0b jo=%h bne=%0b -> pc=%h tgt=%h upd=%0b mis=%0b cnt=%0d",
                     pw, pwc, src, alu, az, tl, jo, bne, pc, target, pc_updated, misaligned, taken_count);
    endtask

    task automatic idle();
        apply(0, 0, 2'd0, 32'h0, 0, 0, 29'h0, 0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        pc_write = 0; pc_write_cond = 0; pc_source = 0; alu_result = 0;
        alu_zero = 0; target_load = 0; jump_offset = 0; branch_ne = 0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_target", target, 32'h0);
        chk("reset_flags", {30'b0, pc_updated, misaligned}, 32'h0);
        chk("reset_count", {16'b0, taken_count}, 32'h0);
        reset = 1'b0;

        apply(1, 0, 2'd0, 32'h4, 0, 0, 29'h0, 0, 1'b1);
        chk("fetch_pc", pc, 32'h4);
        chk("fetch_pulse", {31'b0, pc_updated}, 32'h1);
        chk("fetch_count", {16'b0, taken_count}, 32'h0);
        idle();
        chk("pulse_one_cycle", {31'b0, pc_updated}, 32'h0);

        apply(0, 0, 2'd0, 32'h40, 0, 1, 29'h0, 0, 1'b1);
        chk("target_load", target, 32'h40);
        apply(0, 1, 2'd1, 32'h0, 1, 0, 29'h0, 0, 1'b1);
        chk("beq_taken_pc", pc, 32'h40);
        chk("beq_taken_count", {16'b0, taken_count}, 32'h1);
        apply(0, 1, 2'd1, 32'h0, 0, 0, 29'h0, 0, 1'b1);
        chk("beq_not_taken_pc", pc, 32'h40);
        chk("beq_not_taken_pulse", {31'b0, pc_updated}, 32'h0);

        apply(1, 0, 2'd0, 32'hA000_0010, 0, 0, 29'h0, 0, 1'b1);
        apply(1, 0, 2'd2, 32'h0, 0, 0, 29'h0000100, 0, 1'b1);
        chk("jump_pc", pc, 32'hA000_0100);
        chk("jump_count", {16'b0, taken_count}, 32'h2);

        apply(1, 0, 2'd0, 32'h200, 0, 0, 29'h0, 0, 1'b1);
        apply(1, 0, 2'd0, 32'h204, 0, 0, 29'h0, 0, 1'b1);
        chk("back_to_back_pc", pc, 32'h204);
        chk("back_to_back_pulse", {31'b0, pc_updated}, 32'h1);

        apply(1, 0, 2'd3, 32'h8, 0, 0, 29'h0, 0, 1'b1);
        chk("reserved_src_pc", pc, 32'h204);
        chk("reserved_src_pulse", {31'b0, pc_updated}, 32'h0);

        apply(1, 1, 2'd0, 32'h300, 0, 0, 29'h0, 0, 1'b1);
        chk("both_strobes_pc", pc, 32'h300);

        apply(0, 0, 2'd0, 32'h20, 0, 1, 29'h0, 0, 1'b1);
        apply(1, 0, 2'd1, 32'h80, 0, 1, 29'h0, 0, 1'b1);
        chk("same_cycle_pc", pc, 32'h20);
        chk("same_cycle_target", target, 32'h80);
        chk("same_cycle_count", {16'b0, taken_count}, 32'h3);

        apply(1, 0, 2'd0, 32'h6, 0, 0, 29'h0, 0, 1'b1);
        chk("misalign_pc", pc, 32'h20);
        chk("misalign_flag", {31'b0, misaligned}, 32'h1);
        chk("misalign_pulse", {31'b0, pc_updated}, 32'h0);
        apply(1, 0, 2'd0, 32'h100, 0, 0, 29'h0, 0, 1'b1);
        chk("misalign_blocks_pc", pc, 32'h20);
        apply(0, 0, 2'd0, 32'h44, 0, 1, 29'h0, 0, 1'b1);
        chk("misalign_target_load", target, 32'h44);

        reset = 1'b1;
        apply(1, 0, 2'd0, 32'h500, 0, 1, 29'h0, 0, 1'b1);
        chk("mid_reset_pc", pc, 32'h0);
        chk("mid_reset_target", target, 32'h0);
        chk("mid_reset_flag", {31'b0, misaligned}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 65535; i++)
            apply(1, 0, 2'd2, 32'h0, 0, 0, 29'h100, 0, 1'b0);
        $display("txn 65535 back-to-back jumps -> pc=%h cnt=%0d", pc, taken_count);
        chk("count_max", {16'b0, taken_count}, 32'hFFFF);
        apply(1, 0, 2'd2, 32'h0, 0, 0, 29'h100, 0, 1'b1);
        chk("count_wrap", {16'b0, taken_count}, 32'h0);

`ifdef BRANCH_NE_EN
        apply(0, 0, 2'd0, 32'h60, 0, 1, 29'h0, 0, 1'b1);
        apply(0, 1, 2'd1, 32'h0, 0, 0, 29'h0, 1, 1'b1);
        chk("bne_taken_pc", pc, 32'h60);
        chk("bne_taken_pulse", {31'b0, pc_updated}, 32'h1);
        apply(0, 0, 2'd0, 32'h70, 0, 1, 29'h0, 0, 1'b1);
        apply(0, 1, 2'd1, 32'h0, 1, 0, 29'h0, 1, 1'b1);
        chk("bne_not_taken_pc", pc, 32'h60);
        chk("bne_not_taken_pulse", {31'b0, pc_updated}, 32'h0);
`endif

        idle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
